// File: rtl/seq_multiplier.sv
// ---------------------------------------------------------------------------
// seq_multiplier
//
// Sequential shift-add multiplier. It retires one multiplier bit per clock, so
// a product takes WIDTH cycles. A runtime mode selects unsigned or two's
// complement operands. Signed operands are multiplied as magnitudes, and the
// sign is applied on the final cycle.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   start        request, sampled only while busy=0
//   signed_mode  1 = two's complement operands, 0 = unsigned (sampled with start)
//   a            multiplicand (sampled with start)
//   b            multiplier   (sampled with start)
//   busy         high while a multiplication is in progress
//   done         single-cycle pulse, product valid
//   product      2*WIDTH-bit result, held until the next operation completes
// ---------------------------------------------------------------------------
module seq_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t          state, state_next;
  logic [PW-1:0]   mcand;     // multiplicand, shifted left once per step
  logic [WIDTH-1:0] mplier;   // multiplier, shifted right once per step
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic            accept;
  logic            last;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [PW-1:0]   sum;

  assign accept = (state == IDLE) && start;
  assign last   = (state == CALC) && (cnt == CW'(WIDTH - 1));

  // The magnitude of the most negative value is 2^(WIDTH-1). It fits
  // exactly in WIDTH unsigned bits, so no extra bit is needed.
  assign a_mag = (signed_mode && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign b_mag = (signed_mode && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;

  // The partial sum for this step. On the last step it is the final magnitude.
  assign sum = acc + (mplier[0] ? mcand : '0);

  // State register
  // NOTE: sequential state uses non-blocking (<=) assignments so that every
  // flop samples pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic
  // NOTE: give every always_comb output a default first. Then no path leaves
  // it unassigned, and synthesis cannot infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = CALC;
      CALC: if (last)  state_next = IDLE;
      default:         state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state == CALC);
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= last;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, a_mag};
        mplier <= b_mag;
        neg    <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        acc    <= sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        // Negating zero yields zero, so a zero operand never gives a negative zero.
        if (last) product <= neg ? (~sum + PW'(1)) : sum;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=4 instance
  logic       start4, sm4, busy4, done4;
  logic [3:0] a4, b4;
  logic [7:0] prod4;

  // WIDTH=8 instance
  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] prod8;

  seq_multiplier #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  seq_multiplier #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  typedef struct {
    logic [15:0] exp;
    int          cyc;
  } exp_t;

  exp_t        q4[$], q8[$];
  logic [15:0] hold4 = '0, hold8 = '0;
  int          checks = 0, fails = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the WIDTH=4 instance. It pops one expectation per done pulse.
  // In every other cycle it checks that the product holds its last value.
  always @(negedge clk) begin : mon4
    exp_t e;
    if (mon_en) begin
      if (done4) begin
        check("done4_while_busy", {15'd0, busy4}, 16'd0);
        if (q4.size() == 0) begin
          checks++; fails++;
          $display("FAIL done4_unexpected: got done with product %h, expected no done", prod4);
        end else begin
          e = q4.pop_front();
          check("product4", {8'd0, prod4}, e.exp);
          check("latency4", 16'(cyc - e.cyc), 16'd4);
          hold4 = e.exp;
        end
      end else begin
        check("hold4", {8'd0, prod4}, hold4);
      end
    end
  end

  // Monitor for the WIDTH=8 instance
  always @(negedge clk) begin : mon8
    exp_t e;
    if (mon_en) begin
      if (done8) begin
        check("done8_while_busy", {15'd0, busy8}, 16'd0);
        if (q8.size() == 0) begin
          checks++; fails++;
          $display("FAIL done8_unexpected: got done with product %h, expected no done", prod8);
        end else begin
          e = q8.pop_front();
          check("product8", prod8, e.exp);
          check("latency8", 16'(cyc - e.cyc), 16'd8);
          hold8 = e.exp;
        end
      end else begin
        check("hold8", prod8, hold8);
      end
    end
  end

  // Drivers run at posedge+1 and issue start only once the DUT is idle.
  task automatic do4(input logic sm, input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] exp);
    int n = 0;
    while (busy4 && n < 100) begin @(posedge clk); #1; n++; end
    if (busy4) begin
      checks++; fails++;
      $display("FAIL idle4_timeout: busy still %b, expected 0", busy4);
    end
    sm4 = sm; a4 = a; b4 = b; start4 = 1'b1;
    @(posedge clk); #1;
    q4.push_back('{exp: {8'd0, exp}, cyc: cyc});
    start4 = 1'b0;
  endtask

  task automatic do8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                     input logic [15:0] exp);
    int n = 0;
    while (busy8 && n < 100) begin @(posedge clk); #1; n++; end
    if (busy8) begin
      checks++; fails++;
      $display("FAIL idle8_timeout: busy still %b, expected 0", busy8);
    end
    sm8 = sm; a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    q8.push_back('{exp: exp, cyc: cyc});
    start8 = 1'b0;
  endtask

  function automatic logic [15:0] model8(input logic sm, input logic [7:0] a, input logic [7:0] b);
    int x, y;
    x = sm ? int'($signed(a)) : int'(a);
    y = sm ? int'($signed(b)) : int'(b);
    return 16'(x * y);
  endfunction

  initial begin
    int n;
    logic       sm;
    logic [7:0] ra, rb;

    rst = 1'b1;
    start4 = 0; sm4 = 0; a4 = '0; b4 = '0;
    start8 = 0; sm8 = 0; a8 = '0; b8 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy4", {15'd0, busy4}, 16'd0);
    check("rst_done4", {15'd0, done4}, 16'd0);
    check("rst_prod4", {8'd0, prod4}, 16'd0);
    check("rst_prod8", prod8, 16'd0);
    mon_en = 1'b1;

    // Unsigned full scale
    do4(1'b0, 4'd15, 4'd15, 8'hE1);
    // Signed cases, including most-negative squared
    do4(1'b1, 4'b1101, 4'd5,  8'hF1);
    do4(1'b1, 4'b1000, 4'b1000, 8'h40);
    do4(1'b1, 4'b1000, 4'd7,  8'hC8);

    // Busy, ignored start, back-to-back accept during the done cycle
    do4(1'b0, 4'd3, 4'd4, 8'd12);
    sm4 = 1'b0; a4 = 4'd9; b4 = 4'd9; start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    n = 0;
    while (!done4 && n < 20) begin @(posedge clk); #1; n++; end
    check("done4_seen", {15'd0, done4}, 16'd1);
    a4 = 4'd2; b4 = 4'd5; start4 = 1'b1;
    @(posedge clk); #1;
    q4.push_back('{exp: 16'd10, cyc: cyc});
    start4 = 1'b0;

    // Reset in mid-operation aborts the operation with no done
    do4(1'b0, 4'd7, 4'd7, 8'd49);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q4.delete();
    hold4 = '0;
    check("abort_busy4", {15'd0, busy4}, 16'd0);
    check("abort_done4", {15'd0, done4}, 16'd0);
    check("abort_prod4", {8'd0, prod4}, 16'd0);
    repeat (8) @(posedge clk);
    #1;
    do4(1'b0, 4'd7, 4'd7, 8'd49);

    // Zero and identity
    do4(1'b0, 4'd0,  4'd13, 8'd0);
    do4(1'b0, 4'd11, 4'd1,  8'd11);
    do4(1'b1, 4'd0,  4'b1111, 8'h00);

    // WIDTH=8: directed corners, then a randomised regression
    do8(1'b1, 8'h80, 8'h80, 16'h4000);
    do8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    do8(1'b1, 8'h80, 8'h7F, 16'hC080);
    for (int i = 0; i < 1000; i++) begin
      sm = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      do8(sm, ra, rb, model8(sm, ra, rb));
    end

    // Drain
    n = 0;
    while ((q4.size() != 0 || q8.size() != 0) && n < 100) begin @(posedge clk); n++; end
    if (q4.size() != 0 || q8.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain: %0d/%0d results outstanding, expected 0", q4.size(), q8.size());
    end
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
